// File: rtl/dmem_bus_bridge_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_bus_bridge_if
// Brief    : valid/ready data-memory bus between the load/store bridge and memory
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_bus_bridge_if;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_bus_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_bus_bridge
// Brief    : turns one miniRV load/store into a valid/ready bus access, stalls
//            the core until it completes, applies sb strobes / lbu extension
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bus_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  dmem_bus_bridge_if.master bus
);

  localparam logic [1:0]  c_IDLE     = 2'd0;
  localparam logic [1:0]  c_REQ      = 2'd1;
  localparam logic [1:0]  c_WAIT_R   = 2'd2;
  localparam logic [1:0]  c_DONE     = 2'd3;
  localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;

  logic        r_size;
  logic [1:0]  r_off;
  logic [15:0] r_cnt;

  logic        r_bus_valid;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_wstrb;
  logic [31:0] r_bus_wdata;

  logic        r_done;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_misaligned;
  logic        w_timeout;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [7:0]  w_lane;
  logic        w_valid_n;
  logic        w_done_n;
  logic        w_err_n;
  logic [31:0] w_rdata_n;

  assign w_misaligned = ~cpu_size & (|cpu_addr[1:0]);
  // Last permitted cycle of REQ/WAIT_R: counter already holds TIMEOUT-1.
  assign w_timeout    = (r_cnt >= c_TMO_LAST);

  assign w_wstrb = !cpu_we  ? 4'b0000 :
                   cpu_size ? (4'b0001 << cpu_addr[1:0]) : 4'b1111;
  assign w_wdata = cpu_size ? {4{cpu_wdata[7:0]}} : cpu_wdata;

  always_comb begin
    w_lane = bus.bus_rdata[7:0];
    case (r_off)
      2'd1:    w_lane = bus.bus_rdata[15:8];
      2'd2:    w_lane = bus.bus_rdata[23:16];
      2'd3:    w_lane = bus.bus_rdata[31:24];
      default: w_lane = bus.bus_rdata[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A completing handshake or rvalid beats the timeout in the same cycle, so an
  // accepted request is never silently abandoned by the bridge.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (cpu_req) begin
          w_state_next = w_misaligned ? c_DONE : c_REQ;
        end
      end
      c_REQ: begin
        if (bus.bus_ready) begin
          w_state_next = r_bus_we ? c_DONE : c_WAIT_R;
        end else if (w_timeout) begin
          w_state_next = c_DONE;
        end
      end
      c_WAIT_R: begin
        if (bus.bus_rvalid || w_timeout) begin
          w_state_next = c_DONE;
        end
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_valid_n = (w_state_next == c_REQ);
    w_done_n  = (w_state_next == c_DONE);
    w_err_n   = 1'b0;
    w_rdata_n = 32'h0;
    case (r_state)
      c_IDLE: begin
        w_err_n = cpu_req & w_misaligned;
      end
      c_REQ: begin
        w_err_n = ~bus.bus_ready & w_timeout;
      end
      c_WAIT_R: begin
        if (bus.bus_rvalid) begin
          w_rdata_n = r_size ? {24'h0, w_lane} : bus.bus_rdata;
        end else begin
          w_err_n = w_timeout;
        end
      end
      default: begin
        w_err_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_size      <= 1'b0;
      r_off       <= 2'd0;
      r_cnt       <= 16'd0;
      r_bus_valid <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_wstrb <= 4'h0;
      r_bus_wdata <= 32'h0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
    end else begin
      r_bus_valid <= w_valid_n;
      r_done      <= w_done_n;
      r_err       <= w_err_n;
      r_rdata     <= w_rdata_n;

      if (r_state == c_IDLE) begin
        r_cnt <= 16'd0;
      end else if (r_state == c_REQ || r_state == c_WAIT_R) begin
        r_cnt <= r_cnt + 16'd1;
      end

      if (r_state == c_IDLE && cpu_req) begin
        r_bus_we    <= cpu_we;
        r_size      <= cpu_size;
        r_off       <= cpu_addr[1:0];
        r_bus_addr  <= {cpu_addr[31:2], 2'b00};
        r_bus_wstrb <= w_wstrb;
        r_bus_wdata <= w_wdata;
      end
    end
  end

  assign cpu_stall     = cpu_req & (r_state != c_DONE);
  assign cpu_done      = r_done;
  assign cpu_err       = r_err;
  assign cpu_rdata     = r_rdata;

  assign bus.bus_valid = r_bus_valid;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wstrb = r_bus_wstrb;
  assign bus.bus_wdata = r_bus_wdata;

endmodule
`default_nettype wire
